// File: rtl/meduram_wr_sched.sv
// Two-agent write scheduler in front of the 2W/2R meduram: per-agent FIFOs, same-address
// collision serialisation and a saturating collision counter. MEDURAM_WRSCHED_RR_EN selects
// round-robin collision priority; otherwise agent 1 always wins.
module meduram_wr_sched #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wr1_valid,
    output logic                  wr1_ready,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    input  logic                  wr2_valid,
    output logic                  wr2_ready,
    input  logic [ADDR_WIDTH-1:0] wr2_addr,
    input  logic [DATA_WIDTH-1:0] wr2_data,
    output logic                  wren1,
    output logic [ADDR_WIDTH-1:0] wraddr1,
    output logic [DATA_WIDTH-1:0] wrdata1,
    output logic                  wren2,
    output logic [ADDR_WIDTH-1:0] wraddr2,
    output logic [DATA_WIDTH-1:0] wrdata2,
    output logic [15:0]           collisions
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [1:0]            req_valid;
    logic [EW-1:0]         req [2];

    logic [EW-1:0]         mem_q [2][FIFO_DEPTH];
    logic [PW-1:0]         wptr_q [2];
    logic [PW-1:0]         wptr_d [2];
    logic [PW-1:0]         rptr_q [2];
    logic [PW-1:0]         rptr_d [2];
    logic [PW:0]           cnt_q [2];
    logic [PW:0]           cnt_d [2];
    logic [1:0]            ready_q, ready_d;

    logic [1:0]            wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] wraddr_q [2];
    logic [ADDR_WIDTH-1:0] wraddr_d [2];
    logic [DATA_WIDTH-1:0] wrdata_q [2];
    logic [DATA_WIDTH-1:0] wrdata_d [2];
    logic [15:0]           coll_cnt_q, coll_cnt_d;

    logic [1:0]            push, pop, head_v;
    logic [EW-1:0]         head [2];
    logic                  coll;
    logic                  win1;

`ifdef MEDURAM_WRSCHED_RR_EN
    // 0 selects agent 1 as the next collision winner.
    logic prio_q, prio_d;
`endif

    assign req_valid = {wr2_valid, wr1_valid};
    assign req[0]    = {wr1_addr, wr1_data};
    assign req[1]    = {wr2_addr, wr2_data};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            push[i]   = req_valid[i] & ready_q[i];
            head_v[i] = (cnt_q[i] != '0);
            head[i]   = mem_q[i][rptr_q[i]];
        end

        coll = head_v[0] & head_v[1] &
               (head[0][EW-1:DATA_WIDTH] == head[1][EW-1:DATA_WIDTH]);

`ifdef MEDURAM_WRSCHED_RR_EN
        win1   = ~prio_q;
        prio_d = coll ? ~prio_q : prio_q;
`else
        win1 = 1'b1;
`endif

        pop[0] = head_v[0] & (~coll | win1);
        pop[1] = head_v[1] & (~coll | ~win1);

        for (int i = 0; i < 2; i++) begin
            wptr_d[i] = push[i] ? wptr_q[i] + PTR_ONE : wptr_q[i];
            rptr_d[i] = pop[i]  ? rptr_q[i] + PTR_ONE : rptr_q[i];
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
                default: cnt_d[i] = cnt_q[i];
            endcase
            // Registered ready from the post-update count: no same-cycle reopen when full.
            ready_d[i]  = (cnt_d[i] < DEPTH_CNT);
            wren_d[i]   = pop[i];
            wraddr_d[i] = pop[i] ? head[i][EW-1:DATA_WIDTH] : wraddr_q[i];
            wrdata_d[i] = pop[i] ? head[i][DATA_WIDTH-1:0]  : wrdata_q[i];
        end

        coll_cnt_d = coll_cnt_q;
        if (coll && (coll_cnt_q != 16'hFFFF)) begin
            coll_cnt_d = coll_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 2; i++) begin
                wptr_q[i]   <= '0;
                rptr_q[i]   <= '0;
                cnt_q[i]    <= '0;
                wraddr_q[i] <= '0;
                wrdata_q[i] <= '0;
            end
            ready_q    <= '0;
            wren_q     <= '0;
            coll_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wptr_q[i]   <= wptr_d[i];
                rptr_q[i]   <= rptr_d[i];
                cnt_q[i]    <= cnt_d[i];
                wraddr_q[i] <= wraddr_d[i];
                wrdata_q[i] <= wrdata_d[i];
            end
            ready_q    <= ready_d;
            wren_q     <= wren_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

`ifdef MEDURAM_WRSCHED_RR_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    // Storage needs no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= req[i];
            end
        end
    end

    assign wr1_ready  = ready_q[0];
    assign wr2_ready  = ready_q[1];
    assign wren1      = wren_q[0];
    assign wraddr1    = wraddr_q[0];
    assign wrdata1    = wrdata_q[0];
    assign wren2      = wren_q[1];
    assign wraddr2    = wraddr_q[1];
    assign wrdata2    = wrdata_q[1];
    assign collisions = coll_cnt_q;

endmodule

// File: doc/meduram_wr_sched.md
# meduram_wr_sched

Write scheduler sitting directly upstream of the 2-write/2-read meduram `top`. It buffers write requests from two agents in per-agent FIFOs and drives the RAM's `wren1/wraddr1/wrdata1` and `wren2/wraddr2/wrdata2` ports. It guarantees that the RAM never sees two writes to the same address in the same cycle, by serialising colliding requests under a defined priority. A saturating counter reports how many collisions have occurred.

## Interface
- `ADDR_WIDTH`, 8, RAM address width.
- `DATA_WIDTH`, 32, RAM data width.
- `FIFO_DEPTH`, 4, entries per agent FIFO; power of two, ≥2.

Ports:
- `aclk`  in  1  clock, rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `wr1_valid`  in  1  agent 1 write request valid.
- `wr1_ready`  out  1  agent 1 FIFO can accept.
- `wr1_addr`  in  ADDR_WIDTH  agent 1 write address.
- `wr1_data`  in  DATA_WIDTH  agent 1 write data.
- `wr2_valid`, `wr2_ready`, `wr2_addr`, `wr2_data`  same as agent 1, for agent 2.
- `wren1`  out  1  to RAM write port 1.
- `wraddr1`  out  ADDR_WIDTH  to RAM write port 1.
- `wrdata1`  out  DATA_WIDTH  to RAM write port 1.
- `wren2`, `wraddr2`, `wrdata2`  out  to RAM write port 2.
- `collisions`  out  16  saturating same-address collision count.

## Operation
- **Port mapping:** agent 1 always drives RAM port 1; agent 2 always drives RAM port 2.
- **Push:** a request is pushed into the agent's FIFO on any edge where `wrN_valid & wrN_ready`.
- **Ready:** `wrN_ready` is registered, and equals 1 when the post-update FIFO count is below `FIFO_DEPTH`.
  - A full FIFO deasserts ready even if it pops in the same cycle. There is no pass-through.
- **Per-cycle scheduling on the FIFO heads:**
  - Neither head valid: no pop; `wren1 = wren2 = 0`.
  - Only one head valid, or both valid with different addresses: pop each valid head and issue it on its port.
  - Both valid with equal addresses (collision): pop and issue only the winner; the loser stays at its head and competes again next cycle. `collisions` increments and saturates at 0xFFFF.
- **Winner selection** is set by the Configuration macro.
- **Ordering:** the loser of a collision is always written one or more cycles after the winner, so the loser's data is the final RAM content for that address.
- **Counters:** FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. The count is log2(`FIFO_DEPTH`)+1 bits.

## Timing
- **Reset values** (reset asserted):
  - `wr1_ready = wr2_ready = 0`; they go to 1 on the first `aclk` edge after reset deassertion.
  - `wren1 = wren2 = 0`, and all addr/data outputs 0.
  - `collisions = 0`; FIFOs empty; priority pointer selects agent 1.
- **Reset mid-operation:** reset takes effect asynchronously. FIFO contents are discarded, and in-flight writes are dropped without being issued.
- **Outputs** are registered. An issued write holds `wrenN` high for exactly one cycle.
- **Latency:** a request accepted at edge N into an empty FIFO is issued at edge N+1, so `wrenN` is high in the cycle following edge N+1. Minimum latency is 2 cycles.
- **Throughput:** 1 write per agent per cycle when there are no collisions.
- **Collision loser:** issued no earlier than one cycle after the winner.
- **Simultaneous push and pop** on a non-full FIFO: the count is unchanged.

## Configuration
- Macro: `MEDURAM_WRSCHED_RR_EN`.
- **Defined:** round-robin priority.
  - A 1-bit pointer, reset to agent 1, selects the collision winner.
  - The pointer toggles only on a collision cycle, so that the other agent wins the next collision.
- **Undefined:** fixed priority; agent 1 always wins.
  - Agent 2's data is therefore always the final value on a collision.
  - Agent 2 may starve while agent 1 keeps issuing to the same address.

## Test plan
- **Single write:** reset, then agent 1 pushes addr 0x10, data 0xDEADBEEF.
  - Required: `wren1` pulses one cycle, 2 cycles after acceptance, with the same addr/data; `wren2` stays 0; `collisions = 0`.
- **Parallel disjoint writes:** both agents push 4 requests each on back-to-back cycles, addr 0x00–0x03 and 0x80–0x83.
  - Required: both ports issue every cycle, in FIFO order, with no stall; reading the RAM returns all 8 values.
- **Collision, fixed priority (macro undefined):** both agents push addr 0x20 in the same cycle (agent 1 data 0x11111111, agent 2 data 0x22222222).
  - Required: port 1 issues first; port 2 issues the next cycle; RAM[0x20] = 0x22222222; `collisions = 1`.
- **Collision, round-robin (macro defined):** two collisions on addr 0x30.
  - Required: agent 1 wins the first collision and agent 2 wins the second; `collisions = 2`.
- **Backpressure:** agent 1 pushes 4 requests while agent 2 continuously collides on the same addresses under fixed priority with agent 1 winning.
  - Required: `wr2_ready` drops to 0 after 4 accepted requests; no request is lost or reordered; `wr2_ready` returns to 1 one cycle after the first agent 2 pop.
- **Reset mid-operation:** assert `aresetn = 0` with 3 entries queued per agent.
  - Required: `wren1`/`wren2` drop to 0 immediately; after release, no stale writes are issued; `collisions = 0`.
